gpr_sb: RTL and testbench

//  Parametrised general-purpose register file with integrated busy-register scoreboard and halted-mode debug port.

---
 rtl/gpr_sb.sv | 180 ++++++++++++++++++
 tb/tb_gpr_sb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_sb.sv
`default_nettype none
// ============================================================================
// Module   : gpr_sb
// Purpose  : Multi-port general-purpose register file with a busy-register
//            scoreboard and a halted-mode debug access port.
//            x0 is hardwired to zero. Addresses >= NREG read as zero, are
//            never busy, and ignore writes.
// Ports    : clk, rst (async, active-high)
//            rd_addr/rd_w32 -> rd_data/rd_busy    NRD combinational reads
//            wr_en/wr_addr/wr_w32/wr_data/wr_clr  NWR write-back ports,
//                                                 highest index wins
//            sb_set/sb_addr/sb_flush              scoreboard allocate/flush
//            halted/dbg_req/dbg_wr/dbg_addr/dbg_wdata -> dbg_ack/dbg_rdata
// Config   : GPR_BYPASS_EN - forward same-cycle write-back data and busy
//            clears to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD-1:0]      rd_w32,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR-1:0]      wr_w32,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                sb_flush,
    input  logic                halted,
    input  logic                dbg_req,
    input  logic                dbg_wr,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [XLEN-1:0]     dbg_wdata,
    output logic                dbg_ack,
    output logic [XLEN-1:0]     dbg_rdata
);

    // Replicate bit 31 into the upper half; a no-op when XLEN=32.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] d,
                                               input logic            w32);
        logic [XLEN-1:0] r;
        r = d;
        if (w32) begin
            for (int b = 32; b < XLEN; b++) r[b] = d[31];
        end
        return r;
    endfunction

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            dbg_ack_q, dbg_ack_d;
    logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

    logic [XLEN-1:0] w_wr_ext [NWR];
    logic            w_dbg_acc;

    assign w_dbg_acc = dbg_req & halted;

    generate
        for (genvar j = 0; j < NWR; j++) begin : g_wr
            assign w_wr_ext[j] = sext32(wr_data[j*XLEN +: XLEN], wr_w32[j]);
        end
    endgenerate

    // Next array state. Debug write is applied first so every write port
    // overrides it; ports are then applied in ascending order so the
    // highest-indexed port wins a collision. Loop starts at 1: x0 is never
    // written, and addresses with no matching r fall out naturally.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREG; r++) begin
            if (w_dbg_acc && dbg_wr && dbg_addr == AW'(r))
                regs_d[r] = dbg_wdata;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r))
                    regs_d[r] = w_wr_ext[j];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard: clears first, then set, so a re-allocation in the same
    // cycle as a retirement keeps the register busy. Flush overrides all.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_clr[j] && wr_addr[j*AW +: AW] == AW'(r))
                    busy_d[r] = 1'b0;
            end
            if (sb_set && sb_addr == AW'(r))
                busy_d[r] = 1'b1;
        end
        if (sb_flush)
            busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Debug read samples the pre-edge array; the result holds until the
    // next accepted read.
    always_comb begin
        dbg_ack_d   = w_dbg_acc;
        dbg_rdata_d = dbg_rdata_q;
        if (w_dbg_acc && !dbg_wr) begin
            dbg_rdata_d = '0;
            for (int r = 1; r < NREG; r++) begin
                if (dbg_addr == AW'(r))
                    dbg_rdata_d = regs_q[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
            busy_q      <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
            busy_q      <= busy_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   w_a;
            logic [XLEN-1:0] w_raw;
            logic            w_busy;

            assign w_a = rd_addr[i*AW +: AW];

            always_comb begin
                w_raw  = '0;
                w_busy = 1'b0;
                for (int r = 1; r < NREG; r++) begin
                    if (w_a == AW'(r)) begin
                        w_raw  = regs_q[r];
                        w_busy = busy_q[r];
                    end
                end
`ifdef GPR_BYPASS_EN
                // Matching against r keeps x0 and out-of-range addresses
                // from ever being forwarded.
                for (int r = 1; r < NREG; r++) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && w_a == AW'(r) &&
                            wr_addr[j*AW +: AW] == AW'(r)) begin
                            w_raw = w_wr_ext[j];
                            if (wr_clr[j] && !(sb_set && sb_addr == AW'(r)))
                                w_busy = 1'b0;
                        end
                    end
                end
`endif
            end

            assign rd_data[i*XLEN +: XLEN] = sext32(w_raw, rd_w32[i]);
            assign rd_busy[i]              = w_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpr_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_sb
// Purpose  : Directed self-checking bench for gpr_sb (XLEN=64, NREG=32,
//            NRD=2, NWR=2). Inputs change 1 time unit after the rising
//            edge; outputs are sampled 1-2 units after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD-1:0]      rd_w32;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR-1:0]      wr_w32;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;
    logic                sb_flush;
    logic                halted;
    logic                dbg_req;
    logic                dbg_wr;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_wdata;
    logic                dbg_ack;
    logic [XLEN-1:0]     dbg_rdata;

    int n_checks = 0;
    int n_errors = 0;

    gpr_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_w32    (rd_w32),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_w32    (wr_w32),
        .wr_data   (wr_data),
        .wr_clr    (wr_clr),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .sb_flush  (sb_flush),
        .halted    (halted),
        .dbg_req   (dbg_req),
        .dbg_wr    (dbg_wr),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_clr   = '0;
        wr_w32   = '0;
        sb_set   = 1'b0;
        sb_flush = 1'b0;
        dbg_req  = 1'b0;
        dbg_wr   = 1'b0;
    endtask

    task automatic wport(input int p, input logic [4:0] a, input logic [63:0] d,
                         input logic w32, input logic clr);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*XLEN +: XLEN] = d;
        wr_w32[p]            = w32;
        wr_clr[p]            = clr;
    endtask

    task automatic rport(input int p, input logic [4:0] a, input logic w32);
        rd_addr[p*AW +: AW] = a;
        rd_w32[p]           = w32;
    endtask

    function automatic logic [63:0] rdat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1; halted = 1'b0;
        rd_addr = '0; rd_w32 = '0; wr_addr = '0; wr_data = '0;
        sb_addr = '0; dbg_addr = '0; dbg_wdata = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("reset_ack", {63'd0, dbg_ack}, 64'd0);
        check("reset_rdata", dbg_rdata, 64'd0);

        // Populate state, then reset in the middle of a debug access.
        wport(0, 5'd1, 64'h1234, 1'b0, 1'b0);
        sb_addr = 5'd2; sb_set = 1'b1;
        step(); idle();
        rport(0, 5'd1, 1'b0); rport(1, 5'd2, 1'b0);
        #1;
        check("pre_rst_x1", rdat(0), 64'h1234);
        check("pre_rst_busy_x2", {63'd0, rd_busy[1]}, 64'd1);
        halted = 1'b1; dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd1;
        rst = 1'b1;
        step();
        check("rst_dbg_ack", {63'd0, dbg_ack}, 64'd0);
        check("rst_dbg_rdata", dbg_rdata, 64'd0);
        idle(); halted = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_ack", {63'd0, dbg_ack}, 64'd0);
        for (int r = 1; r < NREG; r++) begin
            rport(0, 5'(r), 1'b0);
            #1;
            check($sformatf("rst_data_x%0d", r), rdat(0), 64'd0);
            check($sformatf("rst_busy_x%0d", r), {63'd0, rd_busy[0]}, 64'd0);
        end

        // x0 discard and sign extension on write and read.
        wport(0, 5'd0, 64'hDEAD, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd0, 1'b0);
        #1;
        check("x0_zero", rdat(0), 64'd0);
        wport(0, 5'd5, 64'h0000_0000_8000_0001, 1'b1, 1'b0);
        wport(1, 5'd6, 64'h0000_0001_7FFF_FFFF, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd5, 1'b0); rport(1, 5'd6, 1'b0);
        #1;
        check("x5_wr_sext", rdat(0), 64'hFFFF_FFFF_8000_0001);
        check("x6_no_sext", rdat(1), 64'h0000_0001_7FFF_FFFF);
        rport(1, 5'd6, 1'b1);
        #1;
        check("x6_rd_w32_pos", rdat(1), 64'h0000_0000_7FFF_FFFF);
        wport(0, 5'd8, 64'h0000_0001_8000_0000, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd8, 1'b1);
        #1;
        check("x8_rd_w32_neg", rdat(0), 64'hFFFF_FFFF_8000_0000);

        // Write-port collision and independent writes.
        wport(0, 5'd7, 64'h11, 1'b0, 1'b0);
        wport(1, 5'd7, 64'h22, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd7, 1'b0);
        #1;
        check("x7_collision", rdat(0), 64'h22);
        wport(0, 5'd10, 64'hA, 1'b0, 1'b0);
        wport(1, 5'd11, 64'hB, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd10, 1'b0); rport(1, 5'd11, 1'b0);
        #1;
        check("x10_port0", rdat(0), 64'hA);
        check("x11_port1", rdat(1), 64'hB);

        // Scoreboard.
        sb_addr = 5'd9; sb_set = 1'b1;
        step(); idle();
        rport(1, 5'd9, 1'b0);
        #1;
        check("x9_busy_set", {63'd0, rd_busy[1]}, 64'd1);
        wport(0, 5'd9, 64'h5, 1'b0, 1'b1);
        sb_addr = 5'd9; sb_set = 1'b1;
        step(); idle();
        #1;
        check("x9_set_wins", {63'd0, rd_busy[1]}, 64'd1);
        check("x9_data", rdat(1), 64'h5);
        wport(0, 5'd9, 64'h6, 1'b0, 1'b1);
        #1;
`ifdef GPR_BYPASS_EN
        check("x9_clr_same_cycle", {63'd0, rd_busy[1]}, 64'd0);
`else
        check("x9_clr_same_cycle", {63'd0, rd_busy[1]}, 64'd1);
`endif
        step(); idle();
        #1;
        check("x9_cleared", {63'd0, rd_busy[1]}, 64'd0);
        sb_addr = 5'd12; sb_set = 1'b1;
        step(); idle();
        wport(1, 5'd12, 64'h7, 1'b0, 1'b0);
        sb_addr = 5'd13; sb_set = 1'b1;
        step(); idle();
        rport(0, 5'd12, 1'b0); rport(1, 5'd13, 1'b0);
        #1;
        check("x12_busy_no_clr", {63'd0, rd_busy[0]}, 64'd1);
        check("x13_busy", {63'd0, rd_busy[1]}, 64'd1);
        sb_flush = 1'b1; sb_addr = 5'd14; sb_set = 1'b1;
        step(); idle();
        #1;
        check("x12_flushed", {63'd0, rd_busy[0]}, 64'd0);
        check("x13_flushed", {63'd0, rd_busy[1]}, 64'd0);
        rport(0, 5'd14, 1'b0);
        #1;
        check("x14_set_dropped", {63'd0, rd_busy[0]}, 64'd0);
        sb_addr = 5'd0; sb_set = 1'b1;
        step(); idle();
        rport(0, 5'd0, 1'b0);
        #1;
        check("x0_never_busy", {63'd0, rd_busy[0]}, 64'd0);

        // Debug port.
        halted = 1'b0; dbg_req = 1'b1; dbg_wr = 1'b1;
        dbg_addr = 5'd3; dbg_wdata = 64'h55;
        step(); idle();
        rport(0, 5'd3, 1'b0);
        #1;
        check("dbg_not_halted_ack", {63'd0, dbg_ack}, 64'd0);
        check("dbg_not_halted_wr", rdat(0), 64'd0);
        halted = 1'b1; dbg_req = 1'b1; dbg_wr = 1'b1;
        step(); idle();
        #1;
        check("dbg_wr_ack", {63'd0, dbg_ack}, 64'd1);
        check("dbg_wr_x3", rdat(0), 64'h55);
        step();
        check("dbg_ack_pulse", {63'd0, dbg_ack}, 64'd0);
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 5'd3;
        step(); idle();
        check("dbg_rd_ack", {63'd0, dbg_ack}, 64'd1);
        check("dbg_rd_data", dbg_rdata, 64'h55);
        step();
        check("dbg_rd_ack_drop", {63'd0, dbg_ack}, 64'd0);
        check("dbg_rd_hold", dbg_rdata, 64'h55);
        wport(0, 5'd15, 64'hAA, 1'b0, 1'b0);
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd15; dbg_wdata = 64'hBB;
        step(); idle();
        rport(0, 5'd15, 1'b0);
        #1;
        check("dbg_wr_port_prio", rdat(0), 64'hAA);
        sb_addr = 5'd16; sb_set = 1'b1;
        step(); idle();
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 5'd16; dbg_wdata = 64'h1;
        step(); idle();
        rport(1, 5'd16, 1'b0);
        #1;
        check("dbg_wr_keeps_busy", {63'd0, rd_busy[1]}, 64'd1);
        check("dbg_wr_x16", rdat(1), 64'h1);
        halted = 1'b0;

        // Same-cycle write/read.
        wport(0, 5'd4, 64'h33, 1'b0, 1'b0);
        step(); idle();
        rport(0, 5'd4, 1'b0);
        wport(0, 5'd4, 64'h99, 1'b0, 1'b0);
        #1;
`ifdef GPR_BYPASS_EN
        check("x4_bypass", rdat(0), 64'h99);
`else
        check("x4_bypass", rdat(0), 64'h33);
`endif
        step(); idle();
        #1;
        check("x4_after", rdat(0), 64'h99);
        wport(0, 5'd4, 64'h1, 1'b0, 1'b0);
        wport(1, 5'd4, 64'h8000_0000, 1'b1, 1'b0);
        rport(1, 5'd0, 1'b0);
        wport(0, 5'd0, 64'h5, 1'b0, 1'b0);
        wport(1, 5'd4, 64'h8000_0000, 1'b1, 1'b0);
        #1;
`ifdef GPR_BYPASS_EN
        check("x4_bypass_prio", rdat(0), 64'hFFFF_FFFF_8000_0000);
`else
        check("x4_bypass_prio", rdat(0), 64'h99);
`endif
        check("x0_no_bypass", rdat(1), 64'd0);
        step(); idle();
        #1;
        check("x4_prio_after", rdat(0), 64'hFFFF_FFFF_8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
